// File: rtl/axi_lite_revision_regs_if.sv
// AXI4-Lite slave-side bundle for the revision register block.
// The slave modport is the register file's view; master is the initiator's view.
interface axi_lite_revision_regs_if #(
  parameter int ADDR_WIDTH = 6,
  parameter int DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0]   S_AXI_AWADDR;
  logic [2:0]              S_AXI_AWPROT;
  logic                    S_AXI_AWVALID;
  logic                    S_AXI_AWREADY;
  logic [DATA_WIDTH-1:0]   S_AXI_WDATA;
  logic [DATA_WIDTH/8-1:0] S_AXI_WSTRB;
  logic                    S_AXI_WVALID;
  logic                    S_AXI_WREADY;
  logic [1:0]              S_AXI_BRESP;
  logic                    S_AXI_BVALID;
  logic                    S_AXI_BREADY;
  logic [ADDR_WIDTH-1:0]   S_AXI_ARADDR;
  logic [2:0]              S_AXI_ARPROT;
  logic                    S_AXI_ARVALID;
  logic                    S_AXI_ARREADY;
  logic [DATA_WIDTH-1:0]   S_AXI_RDATA;
  logic [1:0]              S_AXI_RRESP;
  logic                    S_AXI_RVALID;
  logic                    S_AXI_RREADY;

  modport slave (
    input  S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID,
    output S_AXI_AWREADY,
    input  S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
    output S_AXI_WREADY,
    output S_AXI_BRESP, S_AXI_BVALID,
    input  S_AXI_BREADY,
    input  S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID,
    output S_AXI_ARREADY,
    output S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID,
    input  S_AXI_RREADY
  );

  modport master (
    output S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID,
    input  S_AXI_AWREADY,
    output S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
    input  S_AXI_WREADY,
    input  S_AXI_BRESP, S_AXI_BVALID,
    output S_AXI_BREADY,
    output S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID,
    input  S_AXI_ARREADY,
    input  S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID,
    output S_AXI_RREADY
  );
endinterface

// File: rtl/axi_lite_revision_regs.sv
// AXI4-Lite register file: word 0 is a read-only revision ID, words 1..NUM_REGS-1
// are byte-strobed RW control registers exported to fabric with write pulses.
module axi_lite_revision_regs #(
  parameter int          C_S_AXI_DATA_WIDTH = 32,
  parameter int          C_S_AXI_ADDR_WIDTH = 6,
  parameter int          NUM_REGS           = 8,
  parameter logic [31:0] REVISION           = 32'h0001_0000
) (
  input  logic                    ACLK,
  input  logic                    ARESET,
  axi_lite_revision_regs_if.slave s_axi,
  output logic [32*NUM_REGS-1:0]  reg_out,
  output logic [NUM_REGS-1:0]     reg_wr_pulse
);

  localparam int DW = C_S_AXI_DATA_WIDTH;
  localparam int AW = C_S_AXI_ADDR_WIDTH;
  localparam int SW = DW / 8;
  localparam int IW = AW - 2;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam logic [0:0] W_IDLE = 1'b0;
  localparam logic [0:0] W_RESP = 1'b1;
  localparam logic [0:0] R_IDLE = 1'b0;
  localparam logic [0:0] R_DATA = 1'b1;

  logic                active_q;
  logic [0:0]          wstate_q, wstate_d;
  logic                aw_done_q, aw_done_d;
  logic                w_done_q, w_done_d;
  logic [IW-1:0]       widx_q, widx_d;
  logic [DW-1:0]       wdata_q, wdata_d;
  logic [SW-1:0]       wstrb_q, wstrb_d;
  logic [1:0]          bresp_q, bresp_d;
  logic [NUM_REGS-1:0] upd_q, upd_d;
  logic [NUM_REGS-1:0] pulse_q, pulse_d;
  logic [DW-1:0]       regs_q [NUM_REGS];
  logic [DW-1:0]       regs_d [NUM_REGS];
  logic [0:0]          rstate_q, rstate_d;
  logic [DW-1:0]       rdata_q, rdata_d;
  logic [1:0]          rresp_q, rresp_d;

  logic          awready, wready, arready;
  logic          aw_hs, w_hs, ar_hs, b_hs, r_hs;
  logic [IW-1:0] ridx;
  logic [DW-1:0] rd_word;
  logic          rd_hit;
  logic          unused_ok;

  // Readies stay low until the first clock edge after reset has been released.
  assign awready = active_q && !aw_done_q && (wstate_q == W_IDLE);
  assign wready  = active_q && !w_done_q  && (wstate_q == W_IDLE);
  assign arready = active_q && (rstate_q == R_IDLE);

  assign aw_hs = s_axi.S_AXI_AWVALID && awready;
  assign w_hs  = s_axi.S_AXI_WVALID  && wready;
  assign ar_hs = s_axi.S_AXI_ARVALID && arready;
  assign b_hs  = (wstate_q == W_RESP) && s_axi.S_AXI_BREADY;
  assign r_hs  = (rstate_q == R_DATA) && s_axi.S_AXI_RREADY;

  assign ridx = s_axi.S_AXI_ARADDR[AW-1:2];

  assign unused_ok = ^{s_axi.S_AXI_AWPROT, s_axi.S_AXI_ARPROT,
                       s_axi.S_AXI_AWADDR[1:0], s_axi.S_AXI_ARADDR[1:0]};

  always_comb begin
    rd_word = '0;
    rd_hit  = 1'b0;
    for (int unsigned k = 0; k < NUM_REGS; k++) begin
      if (32'(ridx) == k) begin
        rd_hit  = 1'b1;
        rd_word = (k == 0) ? REVISION : regs_q[k];
      end
    end
  end

  always_comb begin
    wstate_d  = wstate_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    widx_d    = widx_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    bresp_d   = bresp_q;
    regs_d    = regs_q;
    upd_d     = '0;
    pulse_d   = upd_q;

    if (aw_hs) begin
      aw_done_d = 1'b1;
      widx_d    = s_axi.S_AXI_AWADDR[AW-1:2];
    end
    if (w_hs) begin
      w_done_d = 1'b1;
      wdata_d  = s_axi.S_AXI_WDATA;
      wstrb_d  = s_axi.S_AXI_WSTRB;
    end

    case (wstate_q)
      W_IDLE: begin
        // Commit one edge after the later of the two captures.
        if (aw_done_q && w_done_q) begin
          wstate_d = W_RESP;
          bresp_d  = (32'(widx_q) < NUM_REGS) ? RESP_OKAY : RESP_SLVERR;
          for (int unsigned k = 1; k < NUM_REGS; k++) begin
            if (32'(widx_q) == k) begin
              upd_d[k] = 1'b1;
              for (int unsigned b = 0; b < SW; b++) begin
                if (wstrb_q[b]) regs_d[k][8*b +: 8] = wdata_q[8*b +: 8];
              end
            end
          end
        end
      end
      W_RESP: begin
        if (b_hs) begin
          wstate_d  = W_IDLE;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
        end
      end
      default: wstate_d = W_IDLE;
    endcase
  end

  always_comb begin
    rstate_d = rstate_q;
    rdata_d  = rdata_q;
    rresp_d  = rresp_q;
    case (rstate_q)
      R_IDLE: begin
        if (ar_hs) begin
          rstate_d = R_DATA;
          rdata_d  = rd_word;
          rresp_d  = rd_hit ? RESP_OKAY : RESP_SLVERR;
        end
      end
      R_DATA: begin
        if (r_hs) rstate_d = R_IDLE;
      end
      default: rstate_d = R_IDLE;
    endcase
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      active_q  <= 1'b0;
      wstate_q  <= W_IDLE;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      widx_q    <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      bresp_q   <= '0;
      regs_q    <= '{default: '0};
      upd_q     <= '0;
      pulse_q   <= '0;
      rstate_q  <= R_IDLE;
      rdata_q   <= '0;
      rresp_q   <= '0;
    end else begin
      active_q  <= 1'b1;
      wstate_q  <= wstate_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
      widx_q    <= widx_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      bresp_q   <= bresp_d;
      regs_q    <= regs_d;
      upd_q     <= upd_d;
      pulse_q   <= pulse_d;
      rstate_q  <= rstate_d;
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
    end
  end

  assign s_axi.S_AXI_AWREADY = awready;
  assign s_axi.S_AXI_WREADY  = wready;
  assign s_axi.S_AXI_BVALID  = (wstate_q == W_RESP);
  assign s_axi.S_AXI_BRESP   = bresp_q;
  assign s_axi.S_AXI_ARREADY = arready;
  assign s_axi.S_AXI_RVALID  = (rstate_q == R_DATA);
  assign s_axi.S_AXI_RDATA   = rdata_q;
  assign s_axi.S_AXI_RRESP   = rresp_q;

  for (genvar k = 0; k < NUM_REGS; k++) begin : g_out
    if (k == 0) begin : g_rev
      assign reg_out[DW*k +: DW] = REVISION;
    end else begin : g_rw
      assign reg_out[DW*k +: DW] = regs_q[k];
    end
  end

  assign reg_wr_pulse = pulse_q;

endmodule

// File: tb/tb_axi_lite_revision_regs.sv
// Directed and randomized AXI4-Lite traffic against a word-level register model.
module tb_axi_lite_revision_regs;
  localparam int          AW  = 6;
  localparam int          NR  = 8;
  localparam logic [31:0] REV = 32'h0001_0000;
  localparam logic [1:0]  OKAY   = 2'b00;
  localparam logic [1:0]  SLVERR = 2'b10;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  axi_lite_revision_regs_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(32)) bus ();
  logic [32*NR-1:0] reg_out;
  logic [NR-1:0]    reg_wr_pulse;

  axi_lite_revision_regs #(
    .C_S_AXI_DATA_WIDTH(32),
    .C_S_AXI_ADDR_WIDTH(AW),
    .NUM_REGS(NR),
    .REVISION(REV)
  ) dut (
    .ACLK(clk),
    .ARESET(rst),
    .s_axi(bus),
    .reg_out(reg_out),
    .reg_wr_pulse(reg_wr_pulse)
  );

  int n_cmp  = 0;
  int n_fail = 0;
  logic [31:0] m_regs [NR];

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [255:0] model_flat();
    logic [255:0] f = '0;
    for (int k = 0; k < NR; k++) f[32*k +: 32] = (k == 0) ? REV : m_regs[k];
    return f;
  endfunction

  function automatic logic [31:0] model_read(input int idx);
    if (idx == 0) return REV;
    if (idx < NR) return m_regs[idx];
    return 32'h0;
  endfunction

  function automatic void model_write(input int idx, input logic [31:0] data, input logic [3:0] strb);
    logic [31:0] mask = {{8{strb[3]}}, {8{strb[2]}}, {8{strb[1]}}, {8{strb[0]}}};
    if (idx >= 1 && idx < NR) m_regs[idx] = (m_regs[idx] & ~mask) | (data & mask);
  endfunction

  task automatic do_write(input logic [AW-1:0] addr, input logic [31:0] data,
                          input logic [3:0] strb, input int lead, input int hold);
    int idx = int'(addr) / 4;
    int aw_start = (lead > 0) ? lead : 0;
    int w_start  = (lead < 0) ? -lead : 0;
    int cyc = 0;
    bit aw_ok = 0, w_ok = 0, aw_hs, w_hs;
    logic [1:0] exp_resp = (idx < NR) ? OKAY : SLVERR;
    logic [NR-1:0] exp_pulse = '0;
    if (idx >= 1 && idx < NR) exp_pulse[idx] = 1'b1;
    while (!(aw_ok && w_ok) && cyc < 40) begin
      if (!aw_ok && cyc >= aw_start) begin
        bus.S_AXI_AWADDR = addr; bus.S_AXI_AWVALID = 1'b1;
      end
      if (!w_ok && cyc >= w_start) begin
        bus.S_AXI_WDATA = data; bus.S_AXI_WSTRB = strb; bus.S_AXI_WVALID = 1'b1;
      end
      if (w_ok) check("wready_after_w", bus.S_AXI_WREADY, 1'b0);
      if (aw_ok) check("awready_after_aw", bus.S_AXI_AWREADY, 1'b0);
      aw_hs = bus.S_AXI_AWVALID && bus.S_AXI_AWREADY;
      w_hs  = bus.S_AXI_WVALID && bus.S_AXI_WREADY;
      @(posedge clk); #1;
      if (aw_hs) begin aw_ok = 1; bus.S_AXI_AWVALID = 1'b0; end
      if (w_hs)  begin w_ok = 1;  bus.S_AXI_WVALID = 1'b0; end
      cyc++;
    end
    if (!(aw_ok && w_ok)) check("wr_handshake_timeout", {aw_ok, w_ok}, 2'b11);
    bus.S_AXI_AWVALID = 1'b0; bus.S_AXI_WVALID = 1'b0;
    check("bvalid_pre", bus.S_AXI_BVALID, 1'b0);
    @(posedge clk); #1;
    check("bvalid", bus.S_AXI_BVALID, 1'b1);
    check("bresp", bus.S_AXI_BRESP, exp_resp);
    check("pulse_early", reg_wr_pulse, '0);
    model_write(idx, data, strb);
    check("reg_out", reg_out, model_flat());
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      if (i == 0) check("pulse", reg_wr_pulse, exp_pulse);
      check("bvalid_hold", bus.S_AXI_BVALID, 1'b1);
      check("bresp_hold", bus.S_AXI_BRESP, exp_resp);
      check("awready_hold", bus.S_AXI_AWREADY, 1'b0);
      check("wready_hold", bus.S_AXI_WREADY, 1'b0);
    end
    bus.S_AXI_BREADY = 1'b1;
    @(posedge clk); #1;
    if (hold == 0) check("pulse", reg_wr_pulse, exp_pulse);
    bus.S_AXI_BREADY = 1'b0;
    check("bvalid_done", bus.S_AXI_BVALID, 1'b0);
    check("awready_back", bus.S_AXI_AWREADY, 1'b1);
    check("wready_back", bus.S_AXI_WREADY, 1'b1);
    @(posedge clk); #1;
    check("pulse_once", reg_wr_pulse, '0);
  endtask

  task automatic do_read(input logic [AW-1:0] addr, input int hold);
    int idx = int'(addr) / 4;
    int cyc = 0;
    logic [31:0] exp_d = model_read(idx);
    logic [1:0]  exp_r = (idx < NR) ? OKAY : SLVERR;
    bus.S_AXI_ARADDR = addr; bus.S_AXI_ARVALID = 1'b1;
    while (!bus.S_AXI_ARREADY && cyc < 20) begin @(posedge clk); #1; cyc++; end
    check("arready", bus.S_AXI_ARREADY, 1'b1);
    @(posedge clk); #1;
    bus.S_AXI_ARVALID = 1'b0;
    check("rvalid", bus.S_AXI_RVALID, 1'b1);
    check("rdata", bus.S_AXI_RDATA, exp_d);
    check("rresp", bus.S_AXI_RRESP, exp_r);
    check("arready_busy", bus.S_AXI_ARREADY, 1'b0);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check("rvalid_hold", bus.S_AXI_RVALID, 1'b1);
      check("rdata_hold", bus.S_AXI_RDATA, exp_d);
      check("arready_hold", bus.S_AXI_ARREADY, 1'b0);
    end
    bus.S_AXI_RREADY = 1'b1;
    @(posedge clk); #1;
    bus.S_AXI_RREADY = 1'b0;
    check("rvalid_done", bus.S_AXI_RVALID, 1'b0);
    check("arready_back", bus.S_AXI_ARREADY, 1'b1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] old_val, new_val;
    logic [AW-1:0] ra;
    rst = 1'b1;
    bus.S_AXI_AWADDR = '0; bus.S_AXI_AWPROT = 3'b010; bus.S_AXI_AWVALID = 1'b0;
    bus.S_AXI_WDATA = '0;  bus.S_AXI_WSTRB = '0;      bus.S_AXI_WVALID = 1'b0;
    bus.S_AXI_BREADY = 1'b0;
    bus.S_AXI_ARADDR = '0; bus.S_AXI_ARPROT = 3'b101; bus.S_AXI_ARVALID = 1'b0;
    bus.S_AXI_RREADY = 1'b0;
    for (int k = 0; k < NR; k++) m_regs[k] = '0;

    repeat (3) @(posedge clk);
    #1;
    check("rst_awready", bus.S_AXI_AWREADY, 1'b0);
    check("rst_arready", bus.S_AXI_ARREADY, 1'b0);
    check("rst_bvalid", bus.S_AXI_BVALID, 1'b0);
    check("rst_rvalid", bus.S_AXI_RVALID, 1'b0);
    check("rst_rdata", bus.S_AXI_RDATA, '0);
    check("rst_reg_out", reg_out, model_flat());
    check("rst_pulse", reg_wr_pulse, '0);
    rst = 1'b0;
    check("ready_before_edge", bus.S_AXI_WREADY, 1'b0);
    @(posedge clk); #1;
    check("ready_after_edge", {bus.S_AXI_AWREADY, bus.S_AXI_WREADY, bus.S_AXI_ARREADY}, 3'b111);

    // Revision word
    do_read(6'h00, 0);
    do_write(6'h00, 32'hFFFF_FFFF, 4'hF, 0, 0);
    do_read(6'h00, 0);
    do_read(6'h02, 1);

    // Sequential RW words
    for (int k = 1; k < NR; k++) do_write(AW'(4 * k), 32'(k), 4'hF, 0, 0);
    for (int k = 1; k < NR; k++) do_read(AW'(4 * k), 0);

    // Byte strobes
    do_write(6'h04, 32'hAABB_CCDD, 4'hF, 0, 0);
    do_write(6'h04, 32'h1122_3344, 4'b0101, 0, 0);
    do_read(6'h04, 0);
    check("strobe_model", m_regs[1], 32'hAA22_CC44);

    // Channel ordering and B back-pressure
    do_write(6'h08, 32'h0BAD_F00D, 4'hF, 3, 0);
    do_write(6'h0C, 32'h1234_5678, 4'hF, -3, 0);
    do_write(6'h10, 32'hCAFE_BABE, 4'hF, 0, 0);
    do_write(6'h08, 32'h5555_AAAA, 4'hF, 0, 10);
    do_read(6'h08, 5);

    // Out of range
    do_write(6'h20, 32'hDEAD_BEEF, 4'hF, 0, 0);
    do_read(6'h20, 0);
    do_read(6'h3F, 0);

    // AR handshake on the same edge as an update returns the old contents
    old_val = m_regs[2];
    new_val = 32'h7777_1111;
    bus.S_AXI_AWADDR = 6'h08; bus.S_AXI_AWVALID = 1'b1;
    bus.S_AXI_WDATA = new_val; bus.S_AXI_WSTRB = 4'hF; bus.S_AXI_WVALID = 1'b1;
    @(posedge clk); #1;
    bus.S_AXI_AWVALID = 1'b0; bus.S_AXI_WVALID = 1'b0;
    bus.S_AXI_ARADDR = 6'h08; bus.S_AXI_ARVALID = 1'b1;
    @(posedge clk); #1;
    bus.S_AXI_ARVALID = 1'b0;
    check("same_edge_bvalid", bus.S_AXI_BVALID, 1'b1);
    check("same_edge_rvalid", bus.S_AXI_RVALID, 1'b1);
    check("same_edge_rdata", bus.S_AXI_RDATA, old_val);
    model_write(2, new_val, 4'hF);
    check("same_edge_reg_out", reg_out, model_flat());
    bus.S_AXI_BREADY = 1'b1; bus.S_AXI_RREADY = 1'b1;
    @(posedge clk); #1;
    bus.S_AXI_BREADY = 1'b0; bus.S_AXI_RREADY = 1'b0;
    check("same_edge_pulse", reg_wr_pulse, NR'(1 << 2));
    check("same_edge_done", {bus.S_AXI_BVALID, bus.S_AXI_RVALID}, 2'b00);
    @(posedge clk); #1;
    do_read(6'h08, 0);

    // Randomized traffic
    for (int n = 0; n < 60; n++) begin
      ra = AW'($urandom_range(0, 63));
      if ($urandom_range(0, 1) == 1)
        do_write(ra, $urandom, 4'($urandom), int'($urandom_range(0, 6)) - 3,
                 int'($urandom_range(0, 2)));
      else
        do_read(ra, int'($urandom_range(0, 2)));
    end

    // Reset while both B and R responses are outstanding
    bus.S_AXI_AWADDR = 6'h04; bus.S_AXI_AWVALID = 1'b1;
    bus.S_AXI_WDATA = 32'h9999_8888; bus.S_AXI_WSTRB = 4'hF; bus.S_AXI_WVALID = 1'b1;
    bus.S_AXI_ARADDR = 6'h0C; bus.S_AXI_ARVALID = 1'b1;
    @(posedge clk); #1;
    bus.S_AXI_AWVALID = 1'b0; bus.S_AXI_WVALID = 1'b0; bus.S_AXI_ARVALID = 1'b0;
    @(posedge clk); #1;
    check("pre_rst_valids", {bus.S_AXI_BVALID, bus.S_AXI_RVALID}, 2'b11);
    rst = 1'b1;
    @(posedge clk); #1;
    for (int k = 0; k < NR; k++) m_regs[k] = '0;
    check("mid_rst_valids", {bus.S_AXI_BVALID, bus.S_AXI_RVALID}, 2'b00);
    check("mid_rst_readies", {bus.S_AXI_AWREADY, bus.S_AXI_WREADY, bus.S_AXI_ARREADY}, 3'b000);
    check("mid_rst_resp", {bus.S_AXI_BRESP, bus.S_AXI_RRESP}, 4'b0000);
    check("mid_rst_rdata", bus.S_AXI_RDATA, '0);
    check("mid_rst_reg_out", reg_out, model_flat());
    check("mid_rst_pulse", reg_wr_pulse, '0);
    rst = 1'b0;
    @(posedge clk); #1;
    check("post_rst_readies", {bus.S_AXI_AWREADY, bus.S_AXI_WREADY, bus.S_AXI_ARREADY}, 3'b111);
    check("post_rst_pulse", reg_wr_pulse, '0);
    do_read(6'h04, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
